// File: rtl/obuft_serial_drv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : obuft_serial_drv                                             |
// | Description : Serial driver feeding a tri-state pad (I/T). A word accepted |
// |               on a valid/ready handshake is framed by hi-Z turnaround gaps |
// |               and shifted out with the driver enabled. Optional parity:    |
// |               define OBUFT_DRV_PARITY_EN to append an even-parity bit.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module obuft_serial_drv #(
    parameter int WIDTH     = 8,
    parameter int TURN      = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    output logic             RDY,
    output logic             O_I,
    output logic             O_T,
    output logic             BUSY,
    output logic             DONE
);

`ifdef OBUFT_DRV_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    localparam int         c_NB      = WIDTH + c_PAR;
    localparam logic [5:0] c_NB_CNT  = 6'(c_NB);
    localparam logic [3:0] c_TURN_M1 = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("obuft_serial_drv: WIDTH must be in 1..32");
        end
        if (TURN < 0 || TURN > 15) begin : g_bad_turn
            $error("obuft_serial_drv: TURN must be in 0..15");
        end
        if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
            $error("obuft_serial_drv: MSB_FIRST must be 0 or 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_TAIL  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [3:0]      r_tcnt;
    logic [3:0]      w_tcnt_n;
    logic [5:0]      r_bcnt;
    logic [5:0]      w_bcnt_n;
    logic [c_NB-1:0] r_shreg;
    logic [c_NB-1:0] w_shreg_n;
    logic [c_NB-1:0] w_word;
    logic [c_NB-1:0] w_src;
    logic [c_NB-1:0] w_shifted;
    logic            w_bit;
    logic            r_o_i;
    logic            r_o_t;
    logic            r_rdy;
    logic            r_busy;
    logic            r_done;
    logic            w_o_i_n;
    logic            w_o_t_n;
    logic            w_rdy_n;
    logic            w_busy_n;
    logic            w_done_n;

    // Parity bit sits at the end of the shift order, after the last data bit.
`ifdef OBUFT_DRV_PARITY_EN
    logic w_par;
    assign w_par  = ^D;
    assign w_word = (MSB_FIRST != 0) ? {D, w_par} : {w_par, D};
`else
    assign w_word = D;
`endif

    // In IDLE the first bit comes straight from D (TURN = 0 path).
    assign w_src     = (r_state == S_IDLE) ? w_word : r_shreg;
    assign w_bit     = (MSB_FIRST != 0) ? w_src[c_NB-1] : w_src[0];
    assign w_shifted = (MSB_FIRST != 0) ? (w_src << 1) : (w_src >> 1);

    always_comb begin
        w_state_n = r_state;
        w_tcnt_n  = r_tcnt;
        w_bcnt_n  = r_bcnt;
        w_shreg_n = r_shreg;
        w_o_i_n   = 1'b0;
        w_done_n  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (LOAD) begin
                    if (TURN > 0) begin
                        w_state_n = S_LEAD;
                        w_tcnt_n  = c_TURN_M1;
                        w_shreg_n = w_word;
                        w_bcnt_n  = c_NB_CNT;
                    end else begin
                        w_state_n = S_SHIFT;
                        w_o_i_n   = w_bit;
                        w_shreg_n = w_shifted;
                        w_bcnt_n  = c_NB_CNT - 6'd1;
                    end
                end
            end
            S_LEAD: begin
                if (r_tcnt == 4'd0) begin
                    w_state_n = S_SHIFT;
                    w_o_i_n   = w_bit;
                    w_shreg_n = w_shifted;
                    w_bcnt_n  = (r_bcnt != 6'd0) ? r_bcnt - 6'd1 : 6'd0;
                end else begin
                    w_tcnt_n = r_tcnt - 4'd1;
                end
            end
            S_SHIFT: begin
                // r_bcnt holds the bits still to drive after the current one.
                if (r_bcnt != 6'd0) begin
                    w_o_i_n   = w_bit;
                    w_shreg_n = w_shifted;
                    w_bcnt_n  = r_bcnt - 6'd1;
                end else if (TURN > 0) begin
                    w_state_n = S_TAIL;
                    w_tcnt_n  = c_TURN_M1;
                    w_done_n  = (c_TURN_M1 == 4'd0);
                end else begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                end
            end
            S_TAIL: begin
                if (r_tcnt == 4'd0) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_tcnt_n = r_tcnt - 4'd1;
                    w_done_n = (r_tcnt == 4'd1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_o_t_n  = (w_state_n != S_SHIFT);
        w_rdy_n  = (w_state_n == S_IDLE);
        w_busy_n = (w_state_n != S_IDLE);
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_state <= S_IDLE;
            r_tcnt  <= 4'd0;
            r_bcnt  <= 6'd0;
            r_shreg <= '0;
            r_o_i   <= 1'b0;
            r_o_t   <= 1'b1;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_tcnt  <= w_tcnt_n;
            r_bcnt  <= w_bcnt_n;
            r_shreg <= w_shreg_n;
            r_o_i   <= w_o_i_n;
            r_o_t   <= w_o_t_n;
            r_rdy   <= w_rdy_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign O_I  = r_o_i;
    assign O_T  = r_o_t;
    assign RDY  = r_rdy;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_obuft_serial_drv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_obuft_serial_drv                                          |
// | Description : Directed bench for obuft_serial_drv (MSB/TURN=2, LSB/TURN=2, |
// |               MSB/TURN=0 instances).                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_obuft_serial_drv;

`ifdef OBUFT_DRV_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk_c = 1'b0;
    logic       r;
    logic [7:0] d;
    logic [2:0] ld;
    logic       rdy0, oi0, ot0, busy0, done0;
    logic       rdy1, oi1, ot1, busy1, done1;
    logic       rdy2, oi2, ot2, busy2, done2;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk_c = ~clk_c;

    obuft_serial_drv #(.WIDTH(8), .TURN(2), .MSB_FIRST(1)) u_dut0 (
        .C(clk_c), .R(r), .D(d), .LOAD(ld[0]), .RDY(rdy0),
        .O_I(oi0), .O_T(ot0), .BUSY(busy0), .DONE(done0));
    obuft_serial_drv #(.WIDTH(8), .TURN(2), .MSB_FIRST(0)) u_dut1 (
        .C(clk_c), .R(r), .D(d), .LOAD(ld[1]), .RDY(rdy1),
        .O_I(oi1), .O_T(ot1), .BUSY(busy1), .DONE(done1));
    obuft_serial_drv #(.WIDTH(8), .TURN(0), .MSB_FIRST(1)) u_dut2 (
        .C(clk_c), .R(r), .D(d), .LOAD(ld[2]), .RDY(rdy2),
        .O_I(oi2), .O_T(ot2), .BUSY(busy2), .DONE(done2));

    // Observation word: {O_T, O_I, DONE, RDY, BUSY}
    function automatic logic [4:0] get_obs(input int sel);
        case (sel)
            0:       return {ot0, oi0, done0, rdy0, busy0};
            1:       return {ot1, oi1, done1, rdy1, busy1};
            default: return {ot2, oi2, done2, rdy2, busy2};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int sel);
        logic [4:0] o;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_c);
            o = get_obs(sel);
            if (o[1] === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_idle%0d: RDY not seen within 100 cycles", sel);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic [7:0] seq;   // bits in transmit order, seq[7] first
        logic       par;   // even parity of d
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx);
        int         sel;
        int         tn;
        logic [8:0] bits;
        logic [4:0] e;
        logic       b;
        sel  = vecs[idx].sel;
        tn   = (sel == 2) ? 0 : 2;
        bits = {vecs[idx].seq, vecs[idx].par};
        wait_idle(sel);
        @(negedge clk_c);
        d       = vecs[idx].d;
        ld[sel] = 1'b1;
        @(posedge clk_c);
        for (int k = 1; k <= 2 * tn + NB + 1; k++) begin
            @(negedge clk_c);
            if (k == 1) begin
                ld[sel] = 1'b0;
                d       = ~d;
            end
            if (k <= tn) begin
                e = 5'b10001;
            end else if (k <= tn + NB) begin
                b = bits[8 - (k - tn - 1)];
                e = {1'b0, b, 3'b001};
            end else if (k <= 2 * tn + NB) begin
                e = {1'b1, 1'b0, (k == 2 * tn + NB), 2'b01};
            end else begin
                e = {1'b1, 1'b0, (tn == 0), 2'b10};
            end
            chk($sformatf("vec%0d_cyc%0d", idx, k), {27'd0, get_obs(sel)}, {27'd0, e});
        end
    endtask

    initial begin : main
        int         phase;
        int         n1;
        int         n2;
        int         gap;
        logic [8:0] acc1;
        logic [8:0] acc2;
        logic [8:0] exp1;
        logic [8:0] exp2;
        logic [4:0] o;
        logic       saw_done;

        vecs[0] = '{0, 8'hA5, 8'b10100101, 1'b0};
        vecs[1] = '{1, 8'h01, 8'b10000000, 1'b1};
        vecs[2] = '{2, 8'h80, 8'b10000000, 1'b1};
        vecs[3] = '{0, 8'h3C, 8'b00111100, 1'b0};
        vecs[4] = '{1, 8'hC6, 8'b01100011, 1'b0};
        vecs[5] = '{0, 8'h07, 8'b00000111, 1'b1};
        vecs[6] = '{2, 8'h5A, 8'b01011010, 1'b0};

        // Reset held two cycles with LOAD high on every instance
        r  = 1'b1;
        ld = 3'b111;
        d  = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_c);
            for (int s = 0; s < 3; s++)
                chk($sformatf("reset%0d_cyc%0d", s, c), {27'd0, get_obs(s)}, 32'h12);
        end
        r  = 1'b0;
        ld = 3'b000;
        @(negedge clk_c);
        for (int s = 0; s < 3; s++)
            chk($sformatf("post_reset_idle%0d", s), {27'd0, get_obs(s)}, 32'h12);

        for (int i = 0; i < 7; i++) run_vec(i);

        // LOAD held: second word must wait for RDY; D change mid-burst ignored
        wait_idle(0);
        @(negedge clk_c);
        d     = 8'h3C;
        ld[0] = 1'b1;
        @(posedge clk_c);
        phase = 0; n1 = 0; n2 = 0; gap = 0; acc1 = '0; acc2 = '0;
        for (int k = 1; k <= 2 * 2 + NB + 1 + 2 + NB + 1; k++) begin
            @(negedge clk_c);
            if (k == 1) d = 8'hFF;
            o = get_obs(0);
            if (o[4] == 1'b0) begin
                if (phase == 0) phase = 1;
                if (phase == 2) phase = 3;
                if (phase == 1) begin
                    acc1 = {acc1[7:0], o[3]};
                    n1++;
                end else begin
                    acc2 = {acc2[7:0], o[3]};
                    n2++;
                end
            end else begin
                if (phase == 1) phase = 2;
                if (phase == 2) gap++;
            end
        end
        ld[0] = 1'b0;
        exp1 = (NB == 9) ? {8'h3C, 1'b0} : {1'b0, 8'h3C};
        exp2 = (NB == 9) ? {8'hFF, 1'b0} : {1'b0, 8'hFF};
        chk("b2b_first_word", {23'd0, acc1}, {23'd0, exp1});
        chk("b2b_second_word", {23'd0, acc2}, {23'd0, exp2});
        chk("b2b_first_len", n1, NB);
        chk("b2b_second_len", n2, NB);
        // TAIL(2) + IDLE(1) + LEAD(2) between the last and next driven bit
        chk("b2b_gap", gap, 5);
        wait_idle(0);

        // Reset asserted during the 4th SHIFT cycle
        @(negedge clk_c);
        d     = 8'h5A;
        ld[0] = 1'b1;
        @(posedge clk_c);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_c);
            if (k == 1) ld[0] = 1'b0;
        end
        chk("midrst_shift4", {27'd0, get_obs(0)}, 32'h09);
        r = 1'b1;
        @(negedge clk_c);
        chk("midrst_after", {27'd0, get_obs(0)}, 32'h12);
        r = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_c);
            o = get_obs(0);
            if (o[2] !== 1'b0) saw_done = 1'b1;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
        chk("midrst_idle", {27'd0, get_obs(0)}, 32'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
